// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared constants and types for the coin acceptor front end
package coin_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    localparam int UNIT_CINCO = 5;
    localparam int UNIT_DIEZ  = 10;

    typedef enum logic [1:0] {
        COIN_NONE  = 2'd0,
        COIN_CINCO = 2'd1,
        COIN_DIEZ  = 2'd2
    } coin_t;

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - 2-flop synchroniser, debouncer and rising-edge event for one coin sensor
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_2;
                cnt   <= '0;
                rise  <= sync_2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounces coin sensors and serialises accepted coins into single-cycle pulses
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_cinco,
    input  logic raw_diez,
    input  logic accept_block,
    output logic in_cinco,
    output logic in_diez,
    output logic coin_reject,
    output logic pending
);

    logic  level_c;
    logic  level_d;
    logic  ev_c;
    logic  ev_d;
    logic  pend_c;
    logic  pend_d;
    logic  can_issue;
    logic  issue_c;
    logic  issue_d;
    coin_t issue;
    coin_t issue_next;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_cinco (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw_cinco),
        .level (level_c),
        .rise  (ev_c)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_diez (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw_diez),
        .level (level_d),
        .rise  (ev_d)
    );

    // A non-idle issue register enforces the idle gap after every pulse.
    always_comb begin
        can_issue  = !accept_block && (issue == COIN_NONE);
        issue_c    = can_issue && pend_c;
        issue_d    = can_issue && !pend_c && pend_d;
        issue_next = COIN_NONE;
        if (issue_c) begin
            issue_next = COIN_CINCO;
        end else if (issue_d) begin
            issue_next = COIN_DIEZ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_c      <= 1'b0;
            pend_d      <= 1'b0;
            issue       <= COIN_NONE;
            in_cinco    <= 1'b0;
            in_diez     <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            pend_c      <= (pend_c && !issue_c) || ev_c;
            pend_d      <= (pend_d && !issue_d) || ev_d;
            issue       <= issue_next;
            in_cinco    <= issue_c;
            in_diez     <= issue_d;
            coin_reject <= (ev_c && pend_c && !issue_c) || (ev_d && pend_d && !issue_d);
        end
    end

    assign pending = pend_c | pend_d;

    logic unused_levels;
    assign unused_levels = level_c ^ level_d;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - randomized and directed self-checking bench for coin_acceptor
module tb_coin_acceptor;
    import coin_pkg::*;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_cinco = 1'b0;
    logic raw_diez = 1'b0;
    logic accept_block = 1'b0;
    logic in_cinco;
    logic in_diez;
    logic coin_reject;
    logic pending;

    coin_acceptor #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_cinco    (raw_cinco),
        .raw_diez     (raw_diez),
        .accept_block (accept_block),
        .in_cinco     (in_cinco),
        .in_diez      (in_diez),
        .coin_reject  (coin_reject),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int nchk = 0;
    int cyc  = 0;

    // Reference: raw values seen 1 and 2 edges ago, a run length of samples
    // disagreeing with the settled level, one-coin slots and the last issue.
    int ago1[2], ago2[2], lvl[2], run[2], rise[2], pend[2];
    int last_iss = 0;
    int rej = 0;

    int n_c, n_d, n_r, t_c, t_d, t_r;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input int r, input int rc, input int rd, input int blk);
        int ev[2];
        int seen;
        int rawv[2];
        int can, ic, id;
        if (r != 0) begin
            for (int ch = 0; ch < 2; ch++) begin
                ago1[ch] = 0; ago2[ch] = 0; lvl[ch] = 0;
                run[ch] = 0; rise[ch] = 0; pend[ch] = 0;
            end
            last_iss = 0;
            rej = 0;
            return;
        end
        rawv[0] = rc;
        rawv[1] = rd;
        for (int ch = 0; ch < 2; ch++) begin
            ev[ch]   = rise[ch];
            seen     = ago2[ch];
            ago2[ch] = ago1[ch];
            ago1[ch] = rawv[ch];
            rise[ch] = 0;
            if (seen != lvl[ch]) begin
                run[ch]++;
                if (run[ch] == D) begin
                    lvl[ch]  = seen;
                    run[ch]  = 0;
                    rise[ch] = seen;
                end
            end else begin
                run[ch] = 0;
            end
        end
        can = (blk == 0 && last_iss == 0) ? 1 : 0;
        ic  = (can != 0 && pend[0] != 0) ? 1 : 0;
        id  = (can != 0 && pend[0] == 0 && pend[1] != 0) ? 1 : 0;
        rej = ((ev[0] != 0 && pend[0] != 0 && ic == 0) ||
               (ev[1] != 0 && pend[1] != 0 && id == 0)) ? 1 : 0;
        pend[0] = ((pend[0] != 0 && ic == 0) || ev[0] != 0) ? 1 : 0;
        pend[1] = ((pend[1] != 0 && id == 0) || ev[1] != 0) ? 1 : 0;
        last_iss = (ic != 0) ? 1 : (id != 0) ? 2 : 0;
    endtask

    task automatic clr_counts();
        n_c = 0; n_d = 0; n_r = 0;
        t_c = -1; t_d = -1; t_r = -1;
    endtask

    task automatic step(input int r, input int c, input int d, input int b);
        rst          = (r != 0);
        raw_cinco    = (c != 0);
        raw_diez     = (d != 0);
        accept_block = (b != 0);
        @(posedge clk);
        model_edge(r, c, d, b);
        cyc++;
        #1;
        chk("in_cinco", int'(in_cinco), (last_iss == 1) ? 1 : 0);
        chk("in_diez", int'(in_diez), (last_iss == 2) ? 1 : 0);
        chk("coin_reject", int'(coin_reject), rej);
        chk("pending", int'(pending), (pend[0] != 0 || pend[1] != 0) ? 1 : 0);
        chk("one_issue", int'(in_cinco & in_diez), 0);
        if (in_cinco) begin n_c++; t_c = cyc; end
        if (in_diez) begin n_d++; t_d = cyc; end
        if (coin_reject) begin n_r++; t_r = cyc; end
    endtask

    task automatic idle(input int n, input int b);
        for (int i = 0; i < n; i++) step(0, 0, 0, b);
    endtask

    int s, s2, t;
    int rc, rd, rb;

    initial begin
        for (int ch = 0; ch < 2; ch++) begin
            ago1[ch] = 0; ago2[ch] = 0; lvl[ch] = 0;
            run[ch] = 0; rise[ch] = 0; pend[ch] = 0;
        end
        clr_counts();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_outputs", int'({in_cinco, in_diez, coin_reject, pending}), 0);
        idle(4, 0);

        // Clean 5-unit coin
        clr_counts();
        step(0, 1, 0, 0);
        s = cyc;
        for (int i = 0; i < 19; i++) step(0, 1, 0, 0);
        idle(12, 0);
        chk("clean_count_c", n_c, 1);
        chk("clean_latency", t_c - s, 7);
        chk("clean_count_d", n_d, 0);
        chk("clean_reject", n_r, 0);

        // Bouncing 10-unit coin
        clr_counts();
        step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 1, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        s = cyc;
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
        idle(12, 0);
        chk("bounce_count_d", n_d, 1);
        chk("bounce_latency", t_d - s, 7);
        chk("bounce_count_c", n_c, 0);

        // Simultaneous coins
        clr_counts();
        step(0, 1, 1, 0);
        s = cyc;
        for (int i = 0; i < 11; i++) step(0, 1, 1, 0);
        idle(12, 0);
        chk("simul_c_time", t_c - s, 7);
        chk("simul_d_time", t_d - s, 9);
        chk("simul_counts", n_c * 10 + n_d, 11);

        // Blocked then released
        clr_counts();
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
        idle(5, 1);
        chk("blocked_pending", int'(pending), 1);
        chk("blocked_no_pulse", n_c, 0);
        step(0, 0, 0, 0);
        t = cyc;
        idle(10, 0);
        chk("release_time", t_c, t);
        chk("release_count", n_c, 1);

        // Overflow while blocked
        clr_counts();
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1);
        idle(8, 1);
        step(0, 1, 0, 1);
        s2 = cyc;
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1);
        idle(8, 1);
        chk("overflow_rejects", n_r, 1);
        chk("overflow_time", t_r - s2, 6);
        idle(10, 0);
        chk("overflow_issued", n_c, 1);

        // Reset with a pending coin
        clr_counts();
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1);
        idle(8, 1);
        chk("pre_reset_pending", int'(pending), 1);
        step(1, 0, 0, 1);
        chk("in_reset_pending", int'(pending), 0);
        idle(12, 0);
        chk("post_reset_no_diez", n_d, 0);
        chk("post_reset_quiet", int'({in_cinco, in_diez, coin_reject, pending}), 0);

        // Randomised traffic
        rc = 0; rd = 0; rb = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) rc = 1 - rc;
            if ($urandom_range(0, 5) == 0) rd = 1 - rd;
            if ($urandom_range(0, 9) == 0) rb = 1 - rb;
            step(($urandom_range(0, 399) == 0) ? 1 : 0, rc, rd, rb);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage that sits directly upstream of the vending-machine FSM.
- Takes the raw, bouncy coin-slot sensor levels for 5 and 10 units. Synchronises and debounces each one, and turns every accepted coin into a single-cycle in_cinco or in_diez pulse.
- Serialises coin pulses so the FSM never sees both pulses in the same cycle.
- Holds a coin while the FSM is dispensing, and flags coins it has to reject.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples needed before the debounced level changes. Legal range is 2..255.
- CNT_W, 8: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- raw_cinco  input  1  5-unit slot sensor. Asynchronous and may bounce.
- raw_diez  input  1  10-unit slot sensor. Asynchronous and may bounce.
- accept_block  input  1  high while the FSM is dispensing (tied to the FSM's producto). While high, no coin pulse is issued.
- in_cinco  output  1  registered 1-cycle pulse: one 5-unit coin accepted.
- in_diez  output  1  registered 1-cycle pulse: one 10-unit coin accepted.
- coin_reject  output  1  registered 1-cycle pulse: a coin event was discarded on overflow.
- pending  output  1  high while at least one coin is waiting to be issued.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, sync flops 0, debounced levels 0, counters 0, pending flags 0. A reset mid-operation drops any coin in flight or pending; no pulse is emitted for it.
- Synchroniser: each raw input goes through a 2-flop synchroniser.
- Debounce, per channel:
  - When the synchronised value equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while the value still differs, the debounced level takes the new value and the counter clears.
  - Any bounce back to the old level before that point clears the counter.
- Coin event: a 0->1 transition of the debounced level. A 1->0 transition is not an event.
- Pending flags: pend_c and pend_d, one per channel, each holding at most one coin. An event sets its flag.
- Overflow: an event on a channel whose flag is already set, and is not being cleared that cycle, pulses coin_reject for 1 cycle. The coin is lost and the flag stays set.
- Issue arbiter:
  - Runs each cycle when accept_block=0. If pend_c is set: in_cinco=1 next cycle and pend_c clears. Else if pend_d is set: in_diez=1 next cycle and pend_d clears. 5 has priority over 10.
  - When accept_block=1: no issue, and flags are held.
- One-issue rule: at most one pulse per cycle, so in_cinco and in_diez are never high together.
- Gap rule: after any issue, the arbiter waits one idle cycle before the next issue. This gives the FSM state, and therefore accept_block, time to update.
- Simultaneous events: both channels' debounced edges in the same cycle set both flags. in_cinco is issued first; in_diez follows 2 cycles later if still unblocked.
- Event plus issue on the same channel in the same cycle: the flag clears and is re-set by the new event. No reject.
- Latency: if raw is first sampled high at edge N and stays stable, the debounced level rises at edge N+1+DEBOUNCE_CYCLES and the pulse is high in the cycle after edge N+3+DEBOUNCE_CYCLES. That is 7 cycles at default, when unblocked and with no pending coin.
- pending = pend_c | pend_d, driven from registered flags.

Decomposition:
- Package coin_pkg:
  - DEBOUNCE_CYCLES default constant.
  - coin_t enum {COIN_NONE, COIN_CINCO, COIN_DIEZ} for the arbiter's issue register.
  - Unit values 5 and 10 for benches.
- Sub-module coin_debounce: 2-flop synchroniser, counter, debounced level and rise-event output. Instantiated once per channel.
- Top level holds the pending flags, the arbiter/gap logic and the output registers.

Test Plan:
- Clean 5-coin: rst, then raw_cinco high for 20 cycles, accept_block=0 -> exactly one in_cinco pulse, 7 cycles after the first sample; in_diez=0; coin_reject=0.
- Bounce: raw_diez toggles 1,0,1,0 on single cycles, then holds 1 for 10 cycles -> exactly one in_diez pulse, counted from the start of the stable period; no pulse from the glitches.
- Simultaneous: raw_cinco and raw_diez rise on the same cycle -> in_cinco at +7, in_diez at +9; never both high together.
- Blocked: accept_block=1 over the expected issue cycle, then drops at cycle T -> pending=1 while blocked; in_cinco pulses in the cycle after T; exactly once.
- Overflow: accept_block=1, two clean 5-coins (the second after raw has gone low and high again) -> coin_reject pulses once on the second coin's event; after unblock, exactly one in_cinco.
- Reset mid-operation: pend_d set and blocked, assert rst for 1 cycle -> pending=0; no in_diez after unblock; all outputs 0 during and after reset.
